// File: rtl/alu_result_stage_if.sv
// Valid/ready bus between the ALU result muxes, the result stage and its consumer.
// The stage is the slave: it receives in_* and out_ready, and drives in_ready and out_*.
interface alu_result_stage_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic             in_carry;
    logic             in_overflow;
    logic             in_set_flags;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_negative;
    logic             out_zero;
    logic             out_overflow;
    logic             out_carry;

    modport slave (
        input  in_valid, in_result, in_carry, in_overflow, in_set_flags,
        input  out_ready,
        output in_ready, out_valid, out_result,
        output out_negative, out_zero, out_overflow, out_carry
    );

    modport master (
        output in_valid, in_result, in_carry, in_overflow, in_set_flags,
        output out_ready,
        input  in_ready, out_valid, out_result,
        input  out_negative, out_zero, out_overflow, out_carry
    );
endinterface

// File: rtl/alu_result_stage.sv
// Registered two-entry skid buffer behind the ALU result muxes.
// It captures N/Z/V/C per result and updates the status flags when a result is emitted.
module alu_result_stage #(
    parameter int WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    alu_result_stage_if.slave     bus,
    output logic [3:0]            status_nzvc
);
    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             n;
        logic             z;
        logic             v;
        logic             c;
        logic             sf;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e     state_q, state_d;
    entry_t     head_q, head_d;
    entry_t     skid_q, skid_d;
    logic [3:0] status_q, status_d;
    logic       in_ready_q, in_ready_d;

    entry_t new_e;
    logic   acc;
    logic   emit;
    logic   out_valid;

    assign out_valid = (state_q != EMPTY);
    assign acc       = bus.in_valid & in_ready_q;
    assign emit      = out_valid & bus.out_ready;

    always_comb begin
        new_e.result = bus.in_result;
        new_e.n      = bus.in_result[WIDTH-1];
        new_e.z      = (bus.in_result == '0);
        new_e.v      = bus.in_overflow;
        new_e.c      = bus.in_carry;
        new_e.sf     = bus.in_set_flags;
    end

    always_comb begin
        state_d  = state_q;
        head_d   = head_q;
        skid_d   = skid_q;
        status_d = status_q;
        unique case (state_q)
            EMPTY: begin
                if (acc) begin
                    head_d  = new_e;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (acc && emit) begin
                    head_d = new_e;
                end else if (acc) begin
                    skid_d  = new_e;
                    state_d = TWO;
                end else if (emit) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (emit) begin
                    head_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flags track consumed results only, so they change at emit time.
        if (emit && head_q.sf) begin
            status_d = {head_q.n, head_q.z, head_q.v, head_q.c};
        end
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            status_q   <= 4'b0000;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            status_q   <= status_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid;
    assign bus.out_result   = head_q.result;
    assign bus.out_negative = head_q.n;
    assign bus.out_zero     = head_q.z;
    assign bus.out_overflow = head_q.v;
    assign bus.out_carry    = head_q.c;
    assign status_nzvc      = status_q;
endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed vector table, reset and streaming sequences,
// and random handshakes checked against a queue-based reference model.
module tb_alu_result_stage;
    localparam int W = 64;

    logic       clk;
    logic       reset;
    logic [3:0] status_nzvc;

    alu_result_stage_if #(.WIDTH(W)) bus ();

    alu_result_stage #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .status_nzvc (status_nzvc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] r;
        bit           c;
        bit           o;
        bit           sf;
    } item_t;

    item_t      mq[$];
    logic [3:0] m_status;
    int         n_checks;
    int         n_fail;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Compare outputs with the model, then advance both across one clock edge.
    task automatic step();
        bit    acc;
        bit    emit;
        item_t h;
        item_t ni;
        acc  = bus.in_valid && (mq.size() < 2);
        emit = bus.out_ready && (mq.size() > 0);
        chk("in_ready", W'(bus.in_ready), W'(mq.size() < 2));
        chk("out_valid", W'(bus.out_valid), W'(mq.size() > 0));
        chk("status", W'(status_nzvc), W'(m_status));
        if (mq.size() > 0) begin
            h = mq[0];
            chk("out_result", bus.out_result, h.r);
            chk("out_negative", W'(bus.out_negative), W'(h.r >= 64'h8000_0000_0000_0000));
            chk("out_zero", W'(bus.out_zero), W'(h.r == 0));
            chk("out_overflow", W'(bus.out_overflow), W'(h.o));
            chk("out_carry", W'(bus.out_carry), W'(h.c));
        end
        ni.r  = bus.in_result;
        ni.c  = bus.in_carry;
        ni.o  = bus.in_overflow;
        ni.sf = bus.in_set_flags;
        @(posedge clk);
        if (emit) begin
            h = mq.pop_front();
            if (h.sf)
                m_status = {h.r >= 64'h8000_0000_0000_0000, h.r == 0, h.o, h.c};
        end
        if (acc) mq.push_back(ni);
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [W-1:0] r, input bit c,
                         input bit o, input bit sf, input bit rdy);
        bus.in_valid     = v;
        bus.in_result    = r;
        bus.in_carry     = c;
        bus.in_overflow  = o;
        bus.in_set_flags = sf;
        bus.out_ready    = rdy;
    endtask

    typedef struct {
        bit           v;
        logic [W-1:0] r;
        bit           c;
        bit           o;
        bit           sf;
        bit           rdy;
        bit           e_ov;
        bit           e_ir;
        bit           chk_res;
        logic [W-1:0] e_res;
        bit           e_n;
        bit           e_z;
        logic [3:0]   e_st;
    } vec_t;

    vec_t tbl[$];

    initial begin
        item_t        cur;
        bit           have;
        int           sent;
        int           cyc;
        logic [W-1:0] msb;

        n_checks = 0;
        n_fail   = 0;
        m_status = 4'b0000;
        msb      = 64'h8000_0000_0000_0000;

        tbl.push_back('{1, msb, 1, 1, 1, 1, 1, 1, 1, msb, 1, 0, 4'b0000});
        tbl.push_back('{0, 0,   0, 0, 0, 1, 0, 1, 0, 0,   0, 0, 4'b1011});
        tbl.push_back('{1, 5,   0, 0, 0, 0, 1, 1, 1, 5,   0, 0, 4'b1011});
        tbl.push_back('{1, 0,   0, 0, 0, 0, 1, 0, 1, 5,   0, 0, 4'b1011});
        tbl.push_back('{1, 7,   0, 0, 0, 0, 1, 0, 1, 5,   0, 0, 4'b1011});
        tbl.push_back('{1, 7,   0, 0, 0, 1, 1, 1, 1, 0,   0, 1, 4'b1011});
        tbl.push_back('{1, 7,   0, 0, 0, 1, 1, 1, 1, 7,   0, 0, 4'b1011});
        tbl.push_back('{0, 0,   0, 0, 0, 1, 0, 1, 0, 0,   0, 0, 4'b1011});
        tbl.push_back('{1, 0,   0, 0, 1, 1, 1, 1, 1, 0,   0, 1, 4'b1011});
        tbl.push_back('{0, 0,   0, 0, 0, 1, 0, 1, 0, 0,   0, 0, 4'b0100});

        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        chk("rst_out_valid", W'(bus.out_valid), 0);
        chk("rst_in_ready", W'(bus.in_ready), 1);
        chk("rst_out_result", bus.out_result, 0);
        chk("rst_flags", W'({bus.out_negative, bus.out_zero,
                             bus.out_overflow, bus.out_carry}), 0);
        chk("rst_status", W'(status_nzvc), 0);
        repeat (2) step();

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].r, tbl[i].c, tbl[i].o, tbl[i].sf, tbl[i].rdy);
            step();
            chk($sformatf("vec%0d_out_valid", i), W'(bus.out_valid), W'(tbl[i].e_ov));
            chk($sformatf("vec%0d_in_ready", i), W'(bus.in_ready), W'(tbl[i].e_ir));
            chk($sformatf("vec%0d_status", i), W'(status_nzvc), W'(tbl[i].e_st));
            if (tbl[i].chk_res) begin
                chk($sformatf("vec%0d_result", i), bus.out_result, tbl[i].e_res);
                chk($sformatf("vec%0d_neg", i), W'(bus.out_negative), W'(tbl[i].e_n));
                chk($sformatf("vec%0d_zero", i), W'(bus.out_zero), W'(tbl[i].e_z));
            end
        end

        for (int i = 1; i <= 100; i++) begin
            drive(1, W'(i), 0, 0, 0, 1);
            step();
            chk("stream_in_ready", W'(bus.in_ready), 1);
            chk("stream_out_valid", W'(bus.out_valid), 1);
            chk("stream_result", bus.out_result, W'(i));
        end
        drive(0, 0, 0, 0, 0, 1);
        step();

        drive(1, 11, 1, 0, 1, 0);
        step();
        drive(1, 22, 0, 1, 1, 0);
        step();
        chk("pre_rst_in_ready", W'(bus.in_ready), 0);
        reset = 1'b0;
        #1;
        chk("async_rst_out_valid", W'(bus.out_valid), 0);
        chk("async_rst_in_ready", W'(bus.in_ready), 1);
        chk("async_rst_status", W'(status_nzvc), 0);
        mq.delete();
        m_status = 4'b0000;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        step();

        have = 0;
        sent = 0;
        cyc  = 0;
        while ((sent < 1000 || mq.size() > 0) && cyc < 20000) begin
            if (!have && sent < 1000) begin
                case ($urandom_range(0, 3))
                    0: cur.r = '0;
                    1: cur.r = msb | W'($urandom);
                    default: cur.r = {$urandom, $urandom};
                endcase
                cur.c  = 1'($urandom);
                cur.o  = 1'($urandom);
                cur.sf = 1'($urandom);
                have   = 1;
            end
            drive(have && ($urandom_range(0, 3) != 0), cur.r, cur.c, cur.o,
                  cur.sf, $urandom_range(0, 2) != 0);
            if (bus.in_valid && mq.size() < 2) begin
                have = 0;
                sent++;
            end
            step();
            cyc++;
        end
        chk("random_timeout", W'(cyc < 20000), 1);
        chk("random_drained", W'(mq.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the ALU's bit-slice result muxes (one 4:1 select per result bit).
- Captures each ALU result with carry/overflow, computes negative/zero, and buffers up to two results behind a valid/ready handshake.
- Maintains the architectural status-flag register (N, Z, V, C) that conditional-branch logic reads.

Parameters:
- WIDTH, 64, result width in bits (legal range 2 to 64).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream result valid.
- in_ready  output  1  stage can accept a result.
- in_result  input  WIDTH  ALU result.
- in_carry  input  1  ALU carry-out.
- in_overflow  input  1  ALU signed overflow.
- in_set_flags  input  1  this result updates the status flags.
- out_valid  output  1  buffered result available.
- out_ready  input  1  downstream consumes result.
- out_result  output  WIDTH  head result.
- out_negative  output  1  head result MSB.
- out_zero  output  1  head result equals 0.
- out_overflow  output  1  head in_overflow.
- out_carry  output  1  head in_carry.
- status_nzvc  output  4  sticky flags {N,Z,V,C}.

Behaviour:
- Reset (reset=0, asynchronous):
  - Occupancy goes to EMPTY.
  - out_valid=0, in_ready=1, out_result=0, all out_* flags=0, status_nzvc=4'b0000.
  - Buffered entries are discarded, including mid-transfer.
- Accept: in_valid & in_ready at a rising edge. Emit: out_valid & out_ready at a rising edge.
- Capture per accepted entry:
  - result.
  - N = in_result[WIDTH-1].
  - Z = (in_result == 0).
  - V = in_overflow, C = in_carry.
  - set_flags = in_set_flags.
- Storage and state:
  - Two entries: head (drives out_*) and skid.
  - States: EMPTY, ONE, TWO.
  - in_ready = (state != TWO), registered; no combinational path from out_ready.
  - out_valid = (state != EMPTY).
- Transitions:
  - EMPTY: accept -> ONE, entry into head.
  - ONE: accept only -> TWO, entry into skid. Emit only -> EMPTY. Accept and emit together -> ONE, new entry into head.
  - TWO: emit -> ONE, skid moves to head. in_valid is ignored because in_ready=0.
- Latency: an accepted entry appears on out_* at the next rising edge when the stage was EMPTY, or when it was ONE and emitted in the same cycle.
- Ordering: strict FIFO order; no entry dropped or duplicated.
- Stability: while out_valid=1 and out_ready=0, out_* hold stable.
- Upstream rule: in_* need be held only until accepted.
- Idle outputs: when EMPTY, out_result and the out_* flags hold their last values. They are don't-care to consumers but must not be X after reset.
- Status flags:
  - On emit of an entry with set_flags=1, status_nzvc <= {N,Z,V,C} of that entry, visible the cycle after emit.
  - Entries with set_flags=0 leave status_nzvc unchanged.
  - Flags update at emit, not at accept, so status reflects only consumed results.
- Zero detection covers all WIDTH bits. Negative is the MSB only; no sign extension.
- Illegal input: in_valid high while in_ready=0 is legal and is simply not accepted.

Test Plan:
- Reset, then hold in_valid=0 -> out_valid=0, in_ready=1, status_nzvc=0000. Assert reset mid-TWO -> out_valid=0 and in_ready=1 immediately, without waiting for a clock edge.
- Accept in_result=64'h8000_0000_0000_0000, in_carry=1, in_overflow=1, in_set_flags=1, with out_ready=1 -> next cycle out_valid=1, out_negative=1, out_zero=0; after emit, status_nzvc=1011.
- Hold out_ready=0 and offer results 5, 0, 7 on successive cycles:
  - 5 and 0 are accepted; in_ready drops to 0 and 7 stalls.
  - Raise out_ready -> outputs appear in order 5, 0 (out_zero=1), 7.
- Accept result 0 with in_set_flags=0 while status_nzvc=1011 -> after emit, status_nzvc stays 1011.
- Simultaneous accept and emit in ONE for 100 cycles of streaming (values 1..100, out_ready=1) -> one result per cycle, in_ready stays 1, the output sequence equals the input sequence delayed by 1 cycle.
- Random in_valid/out_ready toggling over 1000 random results -> scoreboard shows in-order, lossless delivery; out_* stable whenever stalled.
